div_seq: RTL
============

DIV_SEQ -- requirements
Module: div_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 8, giving the operand/result width in bits (two's complement).
REQ-002 SHALL have port clk  input  1  single system clock; all state changes on rising edge.
REQ-003 SHALL have port n_reset  input  1  reset, asynchronous assert, active-low.
REQ-004 SHALL have port start  input  1  request a division; sampled only when busy=0.
REQ-005 SHALL have port A  input  WIDTH  signed dividend, sampled with start.
REQ-006 SHALL have port B  input  WIDTH  signed divisor, sampled with start.
REQ-007 SHALL have port busy  output  1  high while an accepted division is in progress.
REQ-008 SHALL have port done  output  1  one-cycle pulse; Quot/Rem/dz valid from this cycle.
REQ-009 SHALL have port Quot  output  WIDTH  signed quotient.
REQ-010 SHALL have port dz  output  1  divide-by-zero flag for the last result.
REQ-011 SHALL have port Rem  output  WIDTH  signed remainder, present only under DIV_REM_EN.

Function
REQ-012 SHALL compute Quot = A/B truncated toward zero; Rem = A - B*Quot, sign of Rem equal to sign of A (or zero).
REQ-013 SHALL use a restoring algorithm on magnitudes, one quotient bit per clock, MSB first.
REQ-014 SHALL implement FSM states IDLE, DIVIDE, FIXUP, DONE.
REQ-015 IDLE: start=1 and B!=0 -> latch |A|, |B|, sign bits, clear bit counter, go DIVIDE; start=1 and B=0 -> go DONE with dz result.
REQ-016 DIVIDE: SHALL run exactly WIDTH cycles, counter 0..WIDTH-1, then go FIXUP.
REQ-017 FIXUP: SHALL negate quotient if sign(A)!=sign(B), negate remainder if A<0, register outputs, go DONE.
REQ-018 DONE: SHALL assert done for one cycle and return to IDLE; start in DONE is ignored.
REQ-019 Latency: start sampled at edge 0 -> done high after edge WIDTH+2; busy high after edges 0..WIDTH+1, low with done.
REQ-020 Divide by zero: done high after edge 1; Quot = all ones, Rem = A, dz=1; otherwise dz=0.
REQ-021 Overflow A=-2^(WIDTH-1), B=-1: Quot SHALL wrap to -2^(WIDTH-1), Rem=0, dz=0.
REQ-022 Internal magnitude arithmetic SHALL be WIDTH+1 bits so |-2^(WIDTH-1)| is exact.
REQ-023 start while busy=1 SHALL be ignored, with no effect on the running operation.
REQ-024 Quot, Rem, dz SHALL hold their values from done until the next result is registered.

Reset
REQ-025 n_reset low SHALL immediately force IDLE, busy=0, done=0, dz=0, Quot=0, Rem=0, counter=0.
REQ-026 Reset mid-division SHALL abandon it; no done pulse follows reset release.

Configuration
REQ-027 Macro DIV_REM_EN defined: Rem port and remainder register/negation logic present.
REQ-028 DIV_REM_EN undefined: no Rem port, and the remainder is used only internally as the partial remainder; latency and Quot unchanged.

Structure
REQ-029 Package div_pkg SHALL hold the state enum type and the default WIDTH constant.
REQ-030 One sub-module div_step SHALL implement a single combinational restoring step (shift, trial subtract, quotient bit).

Verification
REQ-031 A=100, B=7, start one cycle -> done after edge 10; Quot=14, Rem=2, dz=0.
REQ-032 A=-100, B=7 -> Quot=-14 (0xF2), Rem=-2 (0xFE); A=100, B=-7 -> Quot=-14, Rem=2.
REQ-033 A=-128, B=-1 -> Quot=-128 (0x80), Rem=0, dz=0; A=-128, B=1 -> Quot=-128.
REQ-034 A=55, B=0 -> done after edge 1, Quot=0xFF, Rem=55, dz=1.
REQ-035 Start A=9,B=3, pulse start again at edge 4 with A=1,B=1 -> only Quot=3 produced, one done.
REQ-036 Start A=50,B=5, n_reset low at edge 5 -> busy=0, Quot=0 immediately; no done; next start computes normally.

Source files
------------

// File: rtl/div_pkg.sv
// Shared types and constants for the sequential signed divider.
//   DIV_WIDTH_DEFAULT : default operand/result width in bits
//   div_state_e       : divider control states
package div_pkg;

  localparam int unsigned DIV_WIDTH_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIVIDE = 2'd1,
    FIXUP  = 2'd2,
    DONE   = 2'd3
  } div_state_e;

endpackage : div_pkg

// File: rtl/div_step.sv
// One combinational restoring-division step on magnitudes.
// The partial remainder and the dividend/quotient register form one long
// shift register: the next dividend bit leaves quo_i at its MSB and the new
// quotient bit enters at its LSB.
//   rem_i / rem_o : partial remainder before / after this step (WIDTH+1)
//   quo_i / quo_o : dividend bits still to process plus quotient so far
//   div_i         : divisor magnitude (WIDTH+1)
module div_step #(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH:0] rem_i,
  input  logic [WIDTH:0] quo_i,
  input  logic [WIDTH:0] div_i,
  output logic [WIDTH:0] rem_o,
  output logic [WIDTH:0] quo_o
);

  localparam int unsigned MW = WIDTH + 1;

  logic [MW:0] shifted;
  logic [MW:0] trial;
  logic        q_bit;

  // Shift in the next dividend bit, trial-subtract, restore on borrow.
  // The partial remainder always stays below the divisor, so the top bit of
  // the trial difference is a clean borrow flag.
  always_comb begin
    shifted = {rem_i, quo_i[WIDTH]};
    trial   = shifted - {1'b0, div_i};
    q_bit   = ~trial[MW];
    rem_o   = q_bit ? MW'(trial) : MW'(shifted);
    quo_o   = {quo_i[WIDTH-1:0], q_bit};
  end

endmodule : div_step

// File: rtl/div_seq.sv
// Sequential signed divider: Quot = A/B truncated toward zero, remainder
// carries the sign of the dividend. Restoring algorithm on WIDTH+1 bit
// magnitudes, one quotient bit per clock, MSB first.
// Optional feature macro: DIV_REM_EN adds the Rem output and its register.
// Ports:
//   clk     : system clock, rising edge
//   n_reset : asynchronous active-low reset
//   start   : request a division (sampled only while busy is low)
//   A, B    : signed dividend / divisor, sampled with start
//   busy    : accepted division in progress
//   done    : one-cycle pulse, results valid from this cycle
//   Quot    : signed quotient (all ones on divide-by-zero)
//   Rem     : signed remainder (DIV_REM_EN only; equals A on divide-by-zero)
//   dz      : divide-by-zero flag for the last result
module div_seq
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             n_reset,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Quot,
`ifdef DIV_REM_EN
  output logic [WIDTH-1:0] Rem,
`endif
  output logic             dz
);

  localparam int unsigned MW = WIDTH + 1;
  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  div_state_e     state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [MW-1:0]  prem_q, prem_d;
  logic [MW-1:0]  quo_q, quo_d;
  logic [MW-1:0]  dvs_q, dvs_d;
  logic           q_neg_q, q_neg_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic           dz_q, dz_d;
  logic [WIDTH-1:0] quot_q, quot_d;
`ifdef DIV_REM_EN
  logic           r_neg_q, r_neg_d;
  logic [WIDTH-1:0] rem_q, rem_d;
`endif

  logic [MW-1:0]  a_ext, b_ext;
  logic [MW-1:0]  a_abs, b_abs;
  logic [MW-1:0]  step_rem, step_quo;

  // Operand magnitudes, one bit wider so |-2^(WIDTH-1)| is exact.
  always_comb begin
    a_ext = {A[WIDTH-1], A};
    b_ext = {B[WIDTH-1], B};
    a_abs = A[WIDTH-1] ? (~a_ext + MW'(1)) : a_ext;
    b_abs = B[WIDTH-1] ? (~b_ext + MW'(1)) : b_ext;
  end

  div_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .rem_i (prem_q),
    .quo_i (quo_q),
    .div_i (dvs_q),
    .rem_o (step_rem),
    .quo_o (step_quo)
  );

  // State and datapath registers.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      prem_q  <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      q_neg_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dz_q    <= 1'b0;
      quot_q  <= '0;
`ifdef DIV_REM_EN
      r_neg_q <= 1'b0;
      rem_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      prem_q  <= prem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      q_neg_q <= q_neg_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dz_q    <= dz_d;
      quot_q  <= quot_d;
`ifdef DIV_REM_EN
      r_neg_q <= r_neg_d;
      rem_q   <= rem_d;
`endif
    end
  end

  // Next-state and datapath control.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    prem_d  = prem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    q_neg_d = q_neg_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    dz_d    = dz_q;
    quot_d  = quot_q;
`ifdef DIV_REM_EN
    r_neg_d = r_neg_q;
    rem_d   = rem_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (start) begin
          busy_d = 1'b1;
          if (B == '0) begin
            // Divide-by-zero result is known at once; skip the iteration.
            dz_d    = 1'b1;
            quot_d  = '1;
`ifdef DIV_REM_EN
            rem_d   = A;
`endif
            state_d = DONE;
          end else begin
            // a_abs[WIDTH] is always zero; seeding it into the partial
            // remainder keeps the full WIDTH+1 bit magnitude in the chain.
            prem_d  = MW'(a_abs[WIDTH]);
            quo_d   = {a_abs[WIDTH-1:0], 1'b0};
            dvs_d   = b_abs;
            q_neg_d = A[WIDTH-1] ^ B[WIDTH-1];
`ifdef DIV_REM_EN
            r_neg_d = A[WIDTH-1];
`endif
            cnt_d   = '0;
            state_d = DIVIDE;
          end
        end
      end

      DIVIDE: begin
        prem_d = step_rem;
        quo_d  = step_quo;
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = FIXUP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      FIXUP: begin
        // Truncation to WIDTH bits makes -2^(WIDTH-1) / -1 wrap to itself.
        quot_d  = WIDTH'(q_neg_q ? (~quo_q + MW'(1)) : quo_q);
`ifdef DIV_REM_EN
        rem_d   = WIDTH'(r_neg_q ? (~prem_q + MW'(1)) : prem_q);
`endif
        dz_d    = 1'b0;
        state_d = DONE;
      end

      DONE: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  assign busy = busy_q;
  assign done = done_q;
  assign Quot = quot_q;
  assign dz   = dz_q;
`ifdef DIV_REM_EN
  assign Rem  = rem_q;
`endif

endmodule : div_seq
